msg_sched_window: RTL

- Parametrised multi-word window register. It succeeds the single-word start-gated 64-bit register.
- Serially loads one DEPTH-word message block, then steps once per round, presenting the current schedule word W[t] and tap words for an external combinational sigma/adder stage.
- Sits between the padding/block buffer and the compression round core.
- Defaults give the SHA-256 schedule. WIDTH=64, ROUNDS=80 give the SHA-512 schedule.

---
 rtl/msg_sched_window.sv | 90 +++++++++
 1 files changed

// File: rtl/msg_sched_window.sv
// msg_sched_window: serially loaded DEPTH-word window that steps once per schedule round
// Ports: CLK/RST clock and sync active-high reset; start begins a block load (IDLE only);
//   in_valid/in_data/in_ready load handshake; wnew_i next word from the external sigma stage;
//   w_valid/w_ready/w_o current word handshake; tap_a_o/tap_b_o/tap_c_o window taps;
//   round_o current round; busy not idle; done one-cycle pulse after the last round.
module msg_sched_window #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ROUNDS = 64,
  parameter int TAP_A  = 14,
  parameter int TAP_B  = 9,
  parameter int TAP_C  = 1,
  parameter int RW     = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [WIDTH-1:0] wnew_i,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [WIDTH-1:0] w_o,
  output logic [WIDTH-1:0] tap_a_o,
  output logic [WIDTH-1:0] tap_b_o,
  output logic [WIDTH-1:0] tap_c_o,
  output logic [RW-1:0]    round_o,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state;
  logic [WIDTH-1:0] win [DEPTH];
  logic [CW-1:0] cnt;
  logic sh;
  logic [WIDTH-1:0] nw;
  logic last;
  always_comb begin
    sh = (state == LOAD && in_valid) || (state == RUN && w_ready);
    nw = state == LOAD ? in_data : wnew_i;
    last = round_o == RW'(ROUNDS - 1);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      state <= IDLE;
      cnt <= '0;
      round_o <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sh) begin
        for (int i = 0; i < DEPTH - 1; i++) win[i] <= win[i+1];
        win[DEPTH-1] <= nw;
      end
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          cnt <= '0;
        end
        LOAD: if (in_valid) begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DEPTH - 1)) begin
            state <= RUN;
            round_o <= '0;
          end
        end
        RUN: if (w_ready) begin
          round_o <= last ? '0 : round_o + 1'b1;
          if (last) begin
            state <= IDLE;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    in_ready = state == LOAD;
    w_valid = state == RUN;
    busy = state != IDLE;
    w_o = win[0];
    tap_a_o = win[TAP_A];
    tap_b_o = win[TAP_B];
    tap_c_o = win[TAP_C];
  end
endmodule
